// File: rtl/mprj_wb_guard.sv
// Wishbone guard between the management core's user-project master port and the user bus.
// Forwards one registered request at a time and aborts it with ERR_DATA if the slave never acks.
module mprj_wb_guard #(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic        core_clk,
   input  logic        core_rst,
   input  logic        mprj_wb_iena,
   input  logic        mprj_cyc_i,
   input  logic        mprj_stb_i,
   input  logic        mprj_we_i,
   input  logic [3:0]  mprj_sel_i,
   input  logic [31:0] mprj_adr_i,
   input  logic [31:0] mprj_dat_i,
   output logic        mprj_ack_o,
   output logic [31:0] mprj_dat_o,
   output logic        u_cyc_o,
   output logic        u_stb_o,
   output logic        u_we_o,
   output logic [3:0]  u_sel_o,
   output logic [31:0] u_adr_o,
   output logic [31:0] u_dat_o,
   input  logic        u_ack_i,
   input  logic [31:0] u_dat_i,
   input  logic        timeout_clr,
   output logic        timeout_flag,
   output logic [31:0] timeout_addr
);

   localparam int            CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic          ack_q;
   logic [31:0]   rdat_q;
   logic          u_cyc_q;
   logic          u_stb_q;
   logic          u_we_q;
   logic [3:0]    u_sel_q;
   logic [31:0]   u_adr_q;
   logic [31:0]   u_dat_q;
   logic          tmo_flag_q;
   logic [31:0]   tmo_addr_q;

   logic req;
   logic cnt_done;

   assign req      = mprj_cyc_i & mprj_stb_i;
   assign cnt_done = (cnt_q == CNT_LAST);

   always_ff @(posedge core_clk or posedge core_rst) begin
      if (core_rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ack_q      <= 1'b0;
         rdat_q     <= '0;
         u_cyc_q    <= 1'b0;
         u_stb_q    <= 1'b0;
         u_we_q     <= 1'b0;
         u_sel_q    <= '0;
         u_adr_q    <= '0;
         u_dat_q    <= '0;
         tmo_flag_q <= 1'b0;
         tmo_addr_q <= '0;
      end else begin
         ack_q <= 1'b0;
         // A timeout later in this block overrides the clear.
         if (timeout_clr) begin
            tmo_flag_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (req) begin
                  if (mprj_wb_iena) begin
                     u_we_q  <= mprj_we_i;
                     u_sel_q <= mprj_sel_i;
                     u_adr_q <= mprj_adr_i;
                     u_dat_q <= mprj_dat_i;
                     u_cyc_q <= 1'b1;
                     u_stb_q <= 1'b1;
                     cnt_q   <= '0;
                     state_q <= ACTIVE;
                  end else begin
                     rdat_q  <= ERR_DATA;
                     ack_q   <= 1'b1;
                     state_q <= RESP;
                  end
               end
            end
            ACTIVE: begin
               if (u_ack_i) begin
                  rdat_q  <= u_dat_i;
                  u_cyc_q <= 1'b0;
                  u_stb_q <= 1'b0;
                  ack_q   <= 1'b1;
                  state_q <= RESP;
               end else if (cnt_done) begin
                  rdat_q     <= ERR_DATA;
                  u_cyc_q    <= 1'b0;
                  u_stb_q    <= 1'b0;
                  tmo_flag_q <= 1'b1;
                  tmo_addr_q <= u_adr_q;
                  ack_q      <= 1'b1;
                  state_q    <= RESP;
               end else if (!mprj_cyc_i) begin
                  u_cyc_q <= 1'b0;
                  u_stb_q <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mprj_ack_o   = ack_q;
   assign mprj_dat_o   = rdat_q;
   assign u_cyc_o      = u_cyc_q;
   assign u_stb_o      = u_stb_q;
   assign u_we_o       = u_we_q;
   assign u_sel_o      = u_sel_q;
   assign u_adr_o      = u_adr_q;
   assign u_dat_o      = u_dat_q;
   assign timeout_flag = tmo_flag_q;
   assign timeout_addr = tmo_addr_q;

endmodule
